// File: rtl/c_crossbar_arb_pkg.sv
// Shared types and helpers for the arbitrated crossbar: per-output FSM state,
// lowest-set-bit isolation and round-robin pointer advance.
package c_crossbar_arb_pkg;

  localparam int unsigned MAX_PORTS = 32;

  typedef enum logic {
    XBAR_IDLE   = 1'b0,
    XBAR_LOCKED = 1'b1
  } xbar_state_e;

  // Keep only the lowest set bit of v (zero stays zero).
  function automatic logic [MAX_PORTS-1:0] lowest_onehot(input logic [MAX_PORTS-1:0] v);
    return v & (~v + MAX_PORTS'(1));
  endfunction

  // Next search start after granting index cur among n ports.
  function automatic int unsigned ptr_advance(input int unsigned cur, input int unsigned n);
    return ((cur + 32'd1) >= n) ? 32'd0 : (cur + 32'd1);
  endfunction

endpackage

// File: rtl/c_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a pointer register that
// advances past the granted requester when update is asserted.
module c_rr_arbiter
  import c_crossbar_arb_pkg::*;
#(
  parameter int unsigned num_ports = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [num_ports-1:0] req,
  input  logic                 update,
  output logic [num_ports-1:0] grant_c
);

  localparam int unsigned PTR_W = (num_ports > 1) ? $clog2(num_ports) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] grant_idx;
  logic             found;
  int unsigned      idx;

  // First requester at or after ptr_q, wrapping.
  always_comb begin
    grant_c   = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < num_ports; k++) begin
      idx = (32'(ptr_q) + k) % num_ports;
      if (!found && req[PTR_W'(idx)]) begin
        found                   = 1'b1;
        grant_c[PTR_W'(idx)]    = 1'b1;
        grant_idx               = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (update) begin
      ptr_q <= PTR_W'(ptr_advance(32'(grant_idx), num_ports));
    end
  end

endmodule

// File: rtl/c_crossbar_arb.sv
// Packet-aware crossbar: per-output round-robin arbitration with grant locked
// until the owner's tail flit transfers. Optional output register: CROSSBAR_OUTPUT_REG_EN.
module c_crossbar_arb
  import c_crossbar_arb_pkg::*;
#(
  parameter int unsigned num_in_ports  = 5,
  parameter int unsigned num_out_ports = 5,
  parameter int unsigned width         = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [num_in_ports-1:0]            in_valid_ip,
  input  logic [num_in_ports*num_out_ports-1:0] in_dest_ip,
  input  logic [num_in_ports-1:0]            in_tail_ip,
  input  logic [num_in_ports*width-1:0]      in_data_ip,
  output logic [num_in_ports-1:0]            in_ready_ip,
  output logic [num_out_ports-1:0]           out_valid_op,
  output logic [num_out_ports-1:0]           out_tail_op,
  output logic [num_out_ports*width-1:0]     out_data_op,
  input  logic [num_out_ports-1:0]           out_ready_op
);

  logic [num_out_ports-1:0] dest_low  [num_in_ports];
  logic [num_in_ports-1:0]  req       [num_out_ports];
  logic [num_in_ports-1:0]  arb_grant [num_out_ports];
  logic [num_in_ports-1:0]  grant     [num_out_ports];
  logic [width-1:0]         sel_data  [num_out_ports];
  logic [num_out_ports-1:0] sel_valid;
  logic [num_out_ports-1:0] sel_tail;
  logic [num_out_ports-1:0] can_accept;
  logic [num_out_ports-1:0] xfer;
  logic [num_out_ports-1:0] arb_update;

  xbar_state_e              state_q [num_out_ports];
  xbar_state_e              state_d [num_out_ports];
  logic [num_in_ports-1:0]  owner_q [num_out_ports];
  logic [num_in_ports-1:0]  owner_d [num_out_ports];

  // Each input requests only the lowest destination bit it presents.
  always_comb begin
    for (int i = 0; i < num_in_ports; i++) begin
      dest_low[i] = num_out_ports'(lowest_onehot(
                      MAX_PORTS'(in_dest_ip[i*num_out_ports +: num_out_ports])));
    end
    for (int o = 0; o < num_out_ports; o++) begin
      for (int i = 0; i < num_in_ports; i++) begin
        req[o][i] = in_valid_ip[i] & dest_low[i][o];
      end
    end
  end

  for (genvar o = 0; o < num_out_ports; o++) begin : g_out
    c_rr_arbiter #(
      .num_ports(num_in_ports)
    ) u_arb (
      .clk    (clk),
      .reset_n(reset_n),
      .req    (req[o]),
      .update (arb_update[o]),
      .grant_c(arb_grant[o])
    );
  end

  // A locked output serves only its owner; otherwise the arbiter decides.
  always_comb begin
    for (int o = 0; o < num_out_ports; o++) begin
      grant[o]     = (state_q[o] == XBAR_LOCKED) ? (req[o] & owner_q[o]) : arb_grant[o];
      sel_valid[o] = |grant[o];
      sel_tail[o]  = |(grant[o] & in_tail_ip);
      xfer[o]      = sel_valid[o] & can_accept[o];
      sel_data[o]  = '0;
      for (int i = 0; i < num_in_ports; i++) begin
        if (grant[o][i]) begin
          sel_data[o] = sel_data[o] | in_data_ip[i*width +: width];
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < num_out_ports; o++) begin
      arb_update[o] = xfer[o] & (state_q[o] == XBAR_IDLE);
    end
  end

  always_comb begin
    in_ready_ip = '0;
    for (int i = 0; i < num_in_ports; i++) begin
      for (int o = 0; o < num_out_ports; o++) begin
        in_ready_ip[i] = in_ready_ip[i] | (grant[o][i] & can_accept[o]);
      end
    end
  end

  // Per-output lock FSM: next state.
  always_comb begin
    for (int o = 0; o < num_out_ports; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      case (state_q[o])
        XBAR_IDLE: begin
          if (xfer[o] && !sel_tail[o]) begin
            state_d[o] = XBAR_LOCKED;
            owner_d[o] = grant[o];
          end
        end
        XBAR_LOCKED: begin
          if (xfer[o] && sel_tail[o]) begin
            state_d[o] = XBAR_IDLE;
            owner_d[o] = '0;
          end
        end
        default: begin
          state_d[o] = XBAR_IDLE;
          owner_d[o] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < num_out_ports; o++) begin
        state_q[o] <= XBAR_IDLE;
        owner_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < num_out_ports; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
      end
    end
  end

`ifdef CROSSBAR_OUTPUT_REG_EN
  logic [num_out_ports-1:0] valid_q;
  logic [num_out_ports-1:0] tail_q;
  logic [width-1:0]         data_q [num_out_ports];

  // A full register accepts a new flit in the cycle it drains.
  always_comb begin
    can_accept = ~valid_q | out_ready_op;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      tail_q  <= '0;
      for (int o = 0; o < num_out_ports; o++) begin
        data_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < num_out_ports; o++) begin
        if (xfer[o]) begin
          valid_q[o] <= 1'b1;
          tail_q[o]  <= sel_tail[o];
          data_q[o]  <= sel_data[o];
        end else if (out_ready_op[o]) begin
          valid_q[o] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    out_valid_op = valid_q;
    out_tail_op  = tail_q;
    for (int o = 0; o < num_out_ports; o++) begin
      out_data_op[o*width +: width] = data_q[o];
    end
  end
`else
  always_comb begin
    can_accept   = out_ready_op;
    out_valid_op = sel_valid;
    out_tail_op  = sel_tail;
    for (int o = 0; o < num_out_ports; o++) begin
      out_data_op[o*width +: width] = sel_data[o];
    end
  end
`endif

endmodule

// File: tb/tb_c_crossbar_arb.sv
// Self-checking bench for c_crossbar_arb: abstract per-output arbitration model
// checked every cycle, plus literal delivery-order expectations per scenario.
module tb_c_crossbar_arb;

  localparam int unsigned NI = 5;
  localparam int unsigned NO = 5;
  localparam int unsigned W  = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NI-1:0]     in_valid_ip;
  logic [NI*NO-1:0]  in_dest_ip;
  logic [NI-1:0]     in_tail_ip;
  logic [NI*W-1:0]   in_data_ip;
  logic [NI-1:0]     in_ready_ip;
  logic [NO-1:0]     out_valid_op;
  logic [NO-1:0]     out_tail_op;
  logic [NO*W-1:0]   out_data_op;
  logic [NO-1:0]     out_ready_op;

  c_crossbar_arb #(
    .num_in_ports (NI),
    .num_out_ports(NO),
    .width        (W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_ip (in_valid_ip),
    .in_dest_ip  (in_dest_ip),
    .in_tail_ip  (in_tail_ip),
    .in_data_ip  (in_data_ip),
    .in_ready_ip (in_ready_ip),
    .out_valid_op(out_valid_op),
    .out_tail_op (out_tail_op),
    .out_data_op (out_data_op),
    .out_ready_op(out_ready_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          once;
    logic [NO-1:0] dest;
    logic          tail;
    logic [W-1:0]  data;
  } flit_t;

  typedef struct packed {
    logic [2:0]   o;
    logic         tail;
    logic [W-1:0] data;
  } rec_t;

  flit_t q [NI][$];
  rec_t  dlog[$];
  bit    fired [NI];
  bit    presented [NI];

  int checks = 0;
  int errors = 0;

  // Model state: lock/owner/pointer per output and optional output register.
  bit            m_lock  [NO];
  int            m_owner [NO];
  int            m_ptr   [NO];
  bit            rv [NO];
  bit            rt [NO];
  logic [W-1:0]  rd [NO];

  task automatic chk(input string name, input logic [NO*W-1:0] act, input logic [NO*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(bit v, bit once, logic [NO-1:0] dest, bit tail, logic [W-1:0] data);
    flit_t f;
    f.v = v; f.once = once; f.dest = dest; f.tail = tail; f.data = data;
    return f;
  endfunction

  always @(negedge clk) begin
    int           dst [NI];
    int           g   [NO];
    bit           can [NO];
    int           idx;
    bit           t;
    logic [NI-1:0]   er;
    logic [NO-1:0]   ev, et;
    logic [NO*W-1:0] ed, dmask;
    if (!reset_n) begin
      for (int o = 0; o < NO; o++) begin
        m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0; rv[o] = 0; rt[o] = 0; rd[o] = '0;
      end
      for (int i = 0; i < NI; i++) fired[i] = 0;
      chk("reset_out_valid", NO*W'(out_valid_op), '0);
      chk("reset_out_tail", NO*W'(out_tail_op), '0);
      chk("reset_out_data", out_data_op, '0);
    end else begin
      for (int i = 0; i < NI; i++) begin
        dst[i] = -1;
        if (in_valid_ip[i])
          for (int o = NO - 1; o >= 0; o--)
            if (in_dest_ip[i*NO + o]) dst[i] = o;
      end
      for (int o = 0; o < NO; o++) begin
        g[o] = -1;
        if (m_lock[o]) begin
          if (dst[m_owner[o]] == o) g[o] = m_owner[o];
        end else begin
          for (int k = 0; k < NI; k++) begin
            idx = (m_ptr[o] + k) % NI;
            if (g[o] < 0 && dst[idx] == o) g[o] = idx;
          end
        end
`ifdef CROSSBAR_OUTPUT_REG_EN
        can[o] = !rv[o] || out_ready_op[o];
`else
        can[o] = out_ready_op[o];
`endif
      end
      er = '0; ev = '0; et = '0; ed = '0; dmask = '0;
      for (int o = 0; o < NO; o++) begin
        if (g[o] >= 0 && can[o]) er[g[o]] = 1'b1;
`ifdef CROSSBAR_OUTPUT_REG_EN
        ev[o] = rv[o];
        et[o] = rt[o];
        ed[o*W +: W] = rd[o];
`else
        ev[o] = (g[o] >= 0);
        if (g[o] >= 0) begin
          et[o] = in_tail_ip[g[o]];
          ed[o*W +: W] = in_data_ip[g[o]*W +: W];
        end
`endif
        if (ev[o]) dmask[o*W +: W] = '1;
      end
      chk("in_ready", NO*W'(in_ready_ip), NO*W'(er));
      chk("out_valid", NO*W'(out_valid_op), NO*W'(ev));
      chk("out_tail", NO*W'(out_tail_op & ev), NO*W'(et & ev));
      chk("out_data", out_data_op & dmask, ed & dmask);
      for (int o = 0; o < NO; o++) begin
        rec_t r;
        if (out_valid_op[o] && out_ready_op[o]) begin
          r.o = 3'(o); r.tail = out_tail_op[o]; r.data = out_data_op[o*W +: W];
          dlog.push_back(r);
        end
      end
      for (int i = 0; i < NI; i++) fired[i] = in_valid_ip[i] && in_ready_ip[i];
      for (int o = 0; o < NO; o++) begin
        if (g[o] >= 0 && can[o]) begin
          t = in_tail_ip[g[o]];
          if (!m_lock[o]) begin
            m_ptr[o] = (g[o] + 1) % NI;
            if (!t) begin m_lock[o] = 1; m_owner[o] = g[o]; end
          end else if (t) begin
            m_lock[o] = 0;
          end
`ifdef CROSSBAR_OUTPUT_REG_EN
          rv[o] = 1; rt[o] = t; rd[o] = in_data_ip[g[o]*W +: W];
        end else if (out_ready_op[o]) begin
          rv[o] = 0;
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (presented[i] && q[i].size() > 0 && (!q[i][0].v || q[i][0].once || fired[i]))
        void'(q[i].pop_front());
      if (q[i].size() > 0) begin
        in_valid_ip[i]          = q[i][0].v;
        in_dest_ip[i*NO +: NO]  = q[i][0].dest;
        in_tail_ip[i]           = q[i][0].tail;
        in_data_ip[i*W +: W]    = q[i][0].data;
        presented[i]            = 1;
      end else begin
        in_valid_ip[i]          = 1'b0;
        in_dest_ip[i*NO +: NO]  = '0;
        in_tail_ip[i]           = 1'b0;
        in_data_ip[i*W +: W]    = '0;
        presented[i]            = 0;
      end
    end
  endtask

  task automatic drain(input string name);
    int  n;
    bit  busy;
    n = 0;
    busy = 1;
    while (busy && n < 200) begin
      step();
      n++;
      busy = 0;
      for (int i = 0; i < NI; i++) if (q[i].size() > 0) busy = 1;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s drain_timeout actual=%0d cycles required=<200", name, n);
    end
    repeat (3) step();
  endtask

  task automatic expect_flit(input string name, input int o, input logic [W-1:0] data, input bit tail);
    int pos;
    pos = -1;
    for (int k = 0; k < dlog.size(); k++)
      if (pos < 0 && int'(dlog[k].o) == o) pos = k;
    if (pos < 0) begin
      checks++;
      errors++;
      $display("FAIL %s missing flit on out%0d actual=none required=%h", name, o, data);
    end else begin
      chk(name, NO*W'({dlog[pos].tail, dlog[pos].data}), NO*W'({tail, data}));
      dlog.delete(pos);
    end
  endtask

  task automatic expect_none(input string name, input int o);
    int c;
    c = 0;
    for (int k = 0; k < dlog.size(); k++) if (int'(dlog[k].o) == o) c++;
    chk(name, NO*W'(c), '0);
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid_ip  = '0;
    in_dest_ip   = '0;
    in_tail_ip   = '0;
    in_data_ip   = '0;
    out_ready_op = '1;
    for (int i = 0; i < NI; i++) begin fired[i] = 0; presented[i] = 0; end
    #1;
    chk("reset_t0_valid", NO*W'(out_valid_op), '0);
    chk("reset_t0_data", out_data_op, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single-flit contention on output 3.
    q[0].push_back(mk(1, 0, 5'b01000, 1, 32'h10));
    q[1].push_back(mk(1, 0, 5'b01000, 1, 32'h11));
    q[2].push_back(mk(1, 0, 5'b01000, 1, 32'h12));
    drain("contend");
    expect_flit("contend_0", 3, 32'h10, 1);
    expect_flit("contend_1", 3, 32'h11, 1);
    expect_flit("contend_2", 3, 32'h12, 1);
    expect_none("contend_extra", 3);

    // Pointer now 3: input 4 beats input 2.
    q[2].push_back(mk(1, 0, 5'b01000, 1, 32'h22));
    q[4].push_back(mk(1, 0, 5'b01000, 1, 32'h24));
    drain("ptr3");
    expect_flit("ptr3_first", 3, 32'h24, 1);
    expect_flit("ptr3_second", 3, 32'h22, 1);
    expect_none("ptr3_extra", 3);

    // Packet lock through a valid gap.
    q[1].push_back(mk(1, 0, 5'b00001, 0, 32'h30));
    q[1].push_back(mk(1, 0, 5'b00001, 0, 32'h31));
    q[1].push_back(mk(0, 0, 5'b00000, 0, 32'h0));
    q[1].push_back(mk(0, 0, 5'b00000, 0, 32'h0));
    q[1].push_back(mk(1, 0, 5'b00001, 0, 32'h32));
    q[1].push_back(mk(1, 0, 5'b00001, 1, 32'h33));
    q[4].push_back(mk(1, 0, 5'b00001, 1, 32'h34));
    drain("lock");
    expect_flit("lock_f0", 0, 32'h30, 0);
    expect_flit("lock_f1", 0, 32'h31, 0);
    expect_flit("lock_f2", 0, 32'h32, 0);
    expect_flit("lock_f3", 0, 32'h33, 1);
    expect_flit("lock_in4", 0, 32'h34, 1);
    expect_none("lock_extra", 0);

    // Backpressure mid-packet on output 2.
    q[0].push_back(mk(1, 0, 5'b00100, 0, 32'h40));
    q[0].push_back(mk(1, 0, 5'b00100, 0, 32'h41));
    q[0].push_back(mk(1, 0, 5'b00100, 0, 32'h42));
    q[0].push_back(mk(1, 0, 5'b00100, 1, 32'h43));
    step();
    step();
    out_ready_op[2] = 1'b0;
    repeat (5) step();
    out_ready_op[2] = 1'b1;
    drain("bp");
    expect_flit("bp_f0", 2, 32'h40, 0);
    expect_flit("bp_f1", 2, 32'h41, 0);
    expect_flit("bp_f2", 2, 32'h42, 0);
    expect_flit("bp_f3", 2, 32'h43, 1);
    expect_none("bp_extra", 2);

    // Five disjoint paths in one cycle.
    q[0].push_back(mk(1, 0, 5'b10000, 1, 32'hA0));
    q[1].push_back(mk(1, 0, 5'b01000, 1, 32'hA1));
    q[2].push_back(mk(1, 0, 5'b00100, 1, 32'hA2));
    q[3].push_back(mk(1, 0, 5'b00010, 1, 32'hA3));
    q[4].push_back(mk(1, 0, 5'b00001, 1, 32'hA4));
    step();
    @(negedge clk);
    chk("parallel_ready", NO*W'(in_ready_ip), NO*W'(5'b11111));
    drain("parallel");
    expect_flit("par_o4", 4, 32'hA0, 1);
    expect_flit("par_o3", 3, 32'hA1, 1);
    expect_flit("par_o2", 2, 32'hA2, 1);
    expect_flit("par_o1", 1, 32'hA3, 1);
    expect_flit("par_o0", 0, 32'hA4, 1);

    // Multi-bit dest uses lowest bit; zero dest is never accepted.
    q[0].push_back(mk(1, 0, 5'b01100, 1, 32'h50));
    for (int k = 0; k < 3; k++) q[1].push_back(mk(1, 1, 5'b00000, 1, 32'h51));
    drain("baddest");
    expect_flit("baddest_o2", 2, 32'h50, 1);
    for (int o = 0; o < NO; o++) expect_none("baddest_extra", o);

    // Reset in the middle of a packet on output 1.
    q[2].push_back(mk(1, 0, 5'b00010, 0, 32'h60));
    q[2].push_back(mk(1, 0, 5'b00010, 0, 32'h61));
    q[2].push_back(mk(1, 0, 5'b00010, 0, 32'h62));
    q[2].push_back(mk(1, 0, 5'b00010, 1, 32'h63));
    repeat (3) step();
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin q[i].delete(); presented[i] = 0; end
    in_valid_ip = '0;
    in_dest_ip  = '0;
    in_tail_ip  = '0;
    in_data_ip  = '0;
    #1;
    chk("rst_mid_valid", NO*W'(out_valid_op), '0);
    chk("rst_mid_data", out_data_op, '0);
    chk("rst_mid_ready", NO*W'(in_ready_ip), '0);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    dlog.delete();
    q[1].push_back(mk(1, 0, 5'b00010, 1, 32'h71));
    q[3].push_back(mk(1, 0, 5'b00010, 1, 32'h73));
    drain("post_reset");
    expect_flit("post_rst_first", 1, 32'h71, 1);
    expect_flit("post_rst_second", 1, 32'h73, 1);
    expect_none("post_rst_extra", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
